// File: rtl/max7219_receiver.sv
// Receiving end of the MAX7219 3-wire serial link: oversamples DIN/CS/SCLK on clk,
// captures 16-bit frames and decodes them into the MAX7219 register file and pixel image.
module max7219_receiver #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        DIN,
  input  logic        CS,
  input  logic        SCLK,
  output logic        frame_valid,
  output logic        frame_err,
  output logic [3:0]  frame_addr,
  output logic [7:0]  frame_data,
  output logic        shutdown_n,
  output logic [7:0]  decode_mode,
  output logic [3:0]  intensity,
  output logic [2:0]  scan_limit,
  output logic        display_test,
  output logic [63:0] rows,
  output logic [63:0] pixels
);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  // Link bundle {DIN, CS, SCLK}; idle value has CS high so reset never fakes an edge.
  localparam logic [2:0] LINK_IDLE = 3'b010;

  logic [2:0] link_raw, link_s, link_h;
  assign link_raw = {DIN, CS, SCLK};

  if (SYNC_STAGES == 0) begin : g_nosync
    assign link_s = link_raw;
  end else begin : g_sync
    logic [2:0] chain [SYNC_STAGES];
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < SYNC_STAGES; i++) chain[i] <= LINK_IDLE;
      end else begin
        chain[0] <= link_raw;
        for (int i = 1; i < SYNC_STAGES; i++) chain[i] <= chain[i-1];
      end
    end
    assign link_s = chain[SYNC_STAGES-1];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) link_h <= LINK_IDLE;
    else     link_h <= link_s;
  end

  logic din_s, cs_rise, cs_fall, sclk_rise;
  assign din_s     = link_s[2];
  assign cs_rise   =  link_s[1] & ~link_h[1];
  assign cs_fall   = ~link_s[1] &  link_h[1];
  assign sclk_rise =  link_s[0] & ~link_h[0];

  state_t state_q, state_d;
  logic   clear_en, shift_en, commit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first, otherwise unassigned paths infer latches.
  always_comb begin
    state_d  = state_q;
    clear_en = 1'b0;
    shift_en = 1'b0;
    commit   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d  = SHIFT;
          clear_en = 1'b1;
        end
      end
      SHIFT: begin
        // CS rising wins over a coincident SCLK rise: that bit is dropped.
        if (cs_rise)        state_d  = COMMIT;
        else if (sclk_rise) shift_en = 1'b1;
      end
      COMMIT: begin
        commit = 1'b1;
        // A one-sample CS high gap means the next frame starts right here.
        if (cs_fall) begin
          state_d  = SHIFT;
          clear_en = 1'b1;
        end else begin
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic [15:0] sh;
  logic [4:0]  cnt;
  logic [2:0]  row_idx;
  assign row_idx = 3'(sh[11:8] - 4'd1);

  // NOTE: the register file is reset explicitly because the device must power up blank and shut down.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh           <= '0;
      cnt          <= '0;
      frame_valid  <= 1'b0;
      frame_err    <= 1'b0;
      frame_addr   <= '0;
      frame_data   <= '0;
      shutdown_n   <= 1'b0;
      decode_mode  <= '0;
      intensity    <= '0;
      scan_limit   <= '0;
      display_test <= 1'b0;
      rows         <= '0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      if (commit) begin
        if (cnt[4]) begin
          frame_valid <= 1'b1;
          frame_addr  <= sh[11:8];
          frame_data  <= sh[7:0];
          case (sh[11:8])
            4'h1, 4'h2, 4'h3, 4'h4,
            4'h5, 4'h6, 4'h7, 4'h8: rows[{row_idx, 3'b000} +: 8] <= sh[7:0];
            4'h9:    decode_mode  <= sh[7:0];
            4'hA:    intensity    <= sh[3:0];
            4'hB:    scan_limit   <= sh[2:0];
            4'hC:    shutdown_n   <= sh[0];
            4'hF:    display_test <= sh[0];
            default: ;
          endcase
        end else begin
          frame_err <= 1'b1;
        end
      end
      if (clear_en) begin
        sh  <= '0;
        cnt <= '0;
      end else if (shift_en) begin
        sh <= {sh[14:0], din_s};
        if (cnt != 5'd31) cnt <= cnt + 5'd1;
      end
    end
  end

  always_comb begin
    pixels = '0;
    if (display_test) begin
      pixels = '1;
    end else if (shutdown_n) begin
      for (int r = 0; r < 8; r++)
        if (3'(r) <= scan_limit) pixels[8*r +: 8] = rows[8*r +: 8];
    end
  end

endmodule

// File: tb/tb_max7219_receiver.sv
// Directed, table-driven bench for max7219_receiver: bit-bangs frames over DIN/CS/SCLK
// and compares decoded registers and pixels with hand-computed values.
module tb_max7219_receiver;

  logic        clk = 1'b0;
  logic        rst;
  logic        DIN, CS, SCLK;
  logic        frame_valid, frame_err;
  logic [3:0]  frame_addr;
  logic [7:0]  frame_data;
  logic        shutdown_n;
  logic [7:0]  decode_mode;
  logic [3:0]  intensity;
  logic [2:0]  scan_limit;
  logic        display_test;
  logic [63:0] rows, pixels;

  max7219_receiver #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .DIN(DIN), .CS(CS), .SCLK(SCLK),
    .frame_valid(frame_valid), .frame_err(frame_err),
    .frame_addr(frame_addr), .frame_data(frame_data),
    .shutdown_n(shutdown_n), .decode_mode(decode_mode), .intensity(intensity),
    .scan_limit(scan_limit), .display_test(display_test),
    .rows(rows), .pixels(pixels)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_valid = 0;
  int n_err   = 0;

  always @(negedge clk) begin
    if (frame_valid) n_valid++;
    if (frame_err)   n_err++;
  end

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic shift_bits(input logic [31:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      DIN = val[i];
      clocks(3);
      SCLK = 1'b1;
      clocks(3);
      SCLK = 1'b0;
    end
  endtask

  // Whole frame; the CS-high hold doubles as the bounded wait for the commit pulse.
  task automatic send_frame(input logic [31:0] val, input int n, input int hold,
                            output int dv, output int de);
    int v0, e0;
    v0 = n_valid;
    e0 = n_err;
    CS = 1'b0;
    clocks(3);
    shift_bits(val, n);
    clocks(3);
    CS = 1'b1;
    clocks(hold);
    dv = n_valid - v0;
    de = n_err - e0;
  endtask

  typedef struct {
    logic [15:0] frame;
    logic [63:0] rows;
    logic [63:0] pix;
    logic        shdn;
    logic [2:0]  scan;
    logic [3:0]  inten;
    logic        dtest;
  } vec_t;

  localparam logic [63:0] FONT0 = 64'h003C_6666_766E_663C;

  vec_t vecs[17];
  int   dv, de, v0, e0;

  initial begin
    vecs[0]  = '{16'h0C01, 64'h0, 64'h0, 1'b1, 3'd0, 4'h0, 1'b0};
    vecs[1]  = '{16'h0900, 64'h0, 64'h0, 1'b1, 3'd0, 4'h0, 1'b0};
    vecs[2]  = '{16'h0B07, 64'h0, 64'h0, 1'b1, 3'd7, 4'h0, 1'b0};
    vecs[3]  = '{16'h0A0A, 64'h0, 64'h0, 1'b1, 3'd7, 4'hA, 1'b0};
    vecs[4]  = '{16'h0F00, 64'h0, 64'h0, 1'b1, 3'd7, 4'hA, 1'b0};
    vecs[5]  = '{16'h013C, 64'h3C, 64'h3C, 1'b1, 3'd7, 4'hA, 1'b0};
    vecs[6]  = '{16'h0266, 64'h663C, 64'h663C, 1'b1, 3'd7, 4'hA, 1'b0};
    vecs[7]  = '{16'h036E, 64'h6E663C, 64'h6E663C, 1'b1, 3'd7, 4'hA, 1'b0};
    vecs[8]  = '{16'h0476, 64'h766E663C, 64'h766E663C, 1'b1, 3'd7, 4'hA, 1'b0};
    vecs[9]  = '{16'h0566, 64'h66766E663C, 64'h66766E663C, 1'b1, 3'd7, 4'hA, 1'b0};
    vecs[10] = '{16'h0666, 64'h6666766E663C, 64'h6666766E663C, 1'b1, 3'd7, 4'hA, 1'b0};
    vecs[11] = '{16'h073C, FONT0, FONT0, 1'b1, 3'd7, 4'hA, 1'b0};
    vecs[12] = '{16'h0800, FONT0, FONT0, 1'b1, 3'd7, 4'hA, 1'b0};
    vecs[13] = '{16'h0B02, FONT0, 64'h6E663C, 1'b1, 3'd2, 4'hA, 1'b0};
    vecs[14] = '{16'h0F01, FONT0, {64{1'b1}}, 1'b1, 3'd2, 4'hA, 1'b1};
    vecs[15] = '{16'h0F00, FONT0, 64'h6E663C, 1'b1, 3'd2, 4'hA, 1'b0};
    vecs[16] = '{16'h0C00, FONT0, 64'h0, 1'b0, 3'd2, 4'hA, 1'b0};

    rst = 1'b1; CS = 1'b1; SCLK = 1'b0; DIN = 1'b0;
    clocks(4);
    rst = 1'b0;
    clocks(50);

    // Idle after reset: shut down, blank, no pulses.
    check("reset_shutdown_n", 64'(shutdown_n), 64'h0);
    check("reset_pixels", pixels, 64'h0);
    check("reset_rows", rows, 64'h0);
    check("reset_pulses", 64'(n_valid + n_err), 64'h0);

    foreach (vecs[k]) begin
      send_frame(32'(vecs[k].frame), 16, 12, dv, de);
      check($sformatf("v%0d_valid_pulses", k), 64'(dv), 64'd1);
      check($sformatf("v%0d_err_pulses", k), 64'(de), 64'd0);
      check($sformatf("v%0d_addr", k), 64'(frame_addr), 64'(vecs[k].frame[11:8]));
      check($sformatf("v%0d_data", k), 64'(frame_data), 64'(vecs[k].frame[7:0]));
      check($sformatf("v%0d_rows", k), rows, vecs[k].rows);
      check($sformatf("v%0d_pixels", k), pixels, vecs[k].pix);
      check($sformatf("v%0d_shutdown_n", k), 64'(shutdown_n), 64'(vecs[k].shdn));
      check($sformatf("v%0d_scan_limit", k), 64'(scan_limit), 64'(vecs[k].scan));
      check($sformatf("v%0d_intensity", k), 64'(intensity), 64'(vecs[k].inten));
      check($sformatf("v%0d_display_test", k), 64'(display_test), 64'(vecs[k].dtest));
    end

    // decode_mode is stored but never alters pixels.
    send_frame(32'h0955, 16, 12, dv, de);
    check("decode_mode", 64'(decode_mode), 64'h55);
    check("decode_pixels", pixels, 64'h0);

    // Short frame: error pulse only, nothing written, last frame fields kept.
    send_frame(32'h0211, 10, 12, dv, de);
    check("short_err_pulses", 64'(de), 64'd1);
    check("short_valid_pulses", 64'(dv), 64'd0);
    check("short_rows", rows, FONT0);
    check("short_addr", 64'(frame_addr), 64'h9);
    check("short_data", 64'(frame_data), 64'h55);

    // 24-bit frame: only the last 16 bits count.
    send_frame(32'hAB0155, 24, 12, dv, de);
    check("long_valid_pulses", 64'(dv), 64'd1);
    check("long_addr", 64'(frame_addr), 64'h1);
    check("long_data", 64'(frame_data), 64'h55);
    check("long_rows", rows, {FONT0[63:8], 8'h55});

    // Reset mid-frame discards it without a pulse.
    v0 = n_valid; e0 = n_err;
    CS = 1'b0;
    clocks(3);
    shift_bits(32'h0377 >> 8, 8);
    rst = 1'b1;
    clocks(2);
    CS = 1'b1;
    clocks(2);
    rst = 1'b0;
    clocks(12);
    check("midrst_pulses", 64'(n_valid - v0 + n_err - e0), 64'd0);
    check("midrst_rows", rows, 64'h0);
    check("midrst_shutdown_n", 64'(shutdown_n), 64'h0);
    send_frame(32'h0377, 16, 12, dv, de);
    check("after_rst_valid", 64'(dv), 64'd1);
    check("after_rst_rows", rows, 64'h770000);

    // Back-to-back frames with CS high for a single sample.
    v0 = n_valid;
    CS = 1'b0;
    clocks(3);
    shift_bits(32'h0155, 16);
    clocks(3);
    CS = 1'b1;
    clocks(1);
    CS = 1'b0;
    clocks(3);
    shift_bits(32'h0266, 16);
    clocks(3);
    CS = 1'b1;
    clocks(12);
    check("b2b_valid_pulses", 64'(n_valid - v0), 64'd2);
    check("b2b_rows", rows, 64'h776655);

    // SCLK and CS rise together: the extra bit must not be shifted in.
    v0 = n_valid;
    CS = 1'b0;
    clocks(3);
    shift_bits(32'h0344, 16);
    DIN = 1'b1;
    clocks(3);
    SCLK = 1'b1;
    CS = 1'b1;
    clocks(3);
    SCLK = 1'b0;
    clocks(12);
    check("tie_valid_pulses", 64'(n_valid - v0), 64'd1);
    check("tie_addr", 64'(frame_addr), 64'h3);
    check("tie_data", 64'(frame_data), 64'h44);
    check("tie_rows", rows, 64'h446655);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
